// File: rtl/uart_frame_loader.sv
// Receive-side frame parser: SYNC, LEN, payload, CSUM from the UART receiver.
// Payload bytes go to a byte-addressed buffer; an ACK/NAK byte is sent back via the transmitter.
module uart_frame_loader #(
  parameter int         MAX_LEN     = 16,
  parameter int         ADDR_W      = 4,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter logic [7:0] ACK_BYTE    = 8'h06,
  parameter logic [7:0] NAK_BYTE    = 8'h15,
  parameter int         TIMEOUT_CYC = 500000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [7:0]        RxData,
  input  logic              RxDone,
  input  logic              TxDone,
  output logic [7:0]        TxData,
  output logic              TxEn,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [7:0]        WrData,
  output logic              FrameDone,
  output logic              FrameErr,
  output logic              Busy,
  output logic [2:0]        DbgState
);

  localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic             rxDoneQ;
  logic             txDoneQ;
  logic             rxEvt;
  logic             txEvt;
  logic [7:0]       len;
  logic [7:0]       idx;
  logic [7:0]       sum;
  logic [7:0]       respByte;
  logic [GAP_W-1:0] gapCnt;
  logic             inFrame;
  logic             timeout;
  logic             lenBad;
  logic             csumOk;

  assign rxEvt   = RxDone & ~rxDoneQ;
  assign txEvt   = TxDone & ~txDoneQ;
  assign inFrame = (state == LEN) || (state == DATA) || (state == CSUM);
  assign timeout = inFrame && (gapCnt == GAP_W'(TIMEOUT_CYC));
  assign lenBad  = (RxData == 8'd0) || (RxData > 8'(MAX_LEN));
  assign csumOk  = (RxData == sum);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Timeout overrides any byte arriving in the same cycle.
  always_comb begin
    stateNext = state;
    if (timeout) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    if (rxEvt && (RxData == SYNC_BYTE)) stateNext = LEN;
        LEN:     if (rxEvt) stateNext = lenBad ? RESP : DATA;
        DATA:    if (rxEvt && ((idx + 8'd1) == len)) stateNext = CSUM;
        CSUM:    if (rxEvt) stateNext = RESP;
        RESP:    if (txEvt) stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // TxEn is combinational so it falls in the tx_evt cycle and the instant Rst rises.
  always_comb begin
    TxEn     = (state == RESP) && !txEvt;
    TxData   = (state == RESP) ? respByte : 8'd0;
    Busy     = (state != IDLE);
    DbgState = state;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rxDoneQ   <= 1'b0;
      txDoneQ   <= 1'b0;
      len       <= '0;
      idx       <= '0;
      sum       <= '0;
      respByte  <= '0;
      gapCnt    <= '0;
      WrEn      <= 1'b0;
      WrAddr    <= '0;
      WrData    <= '0;
      FrameDone <= 1'b0;
      FrameErr  <= 1'b0;
    end else begin
      rxDoneQ   <= RxDone;
      txDoneQ   <= TxDone;
      WrEn      <= 1'b0;
      FrameDone <= 1'b0;
      FrameErr  <= 1'b0;
      if (!inFrame || rxEvt) gapCnt <= '0;
      else                   gapCnt <= gapCnt + 1'b1;

      if (timeout) begin
        FrameErr <= 1'b1;
      end else if (rxEvt) begin
        case (state)
          LEN: begin
            len <= RxData;
            sum <= RxData;
            idx <= '0;
            if (lenBad) begin
              respByte <= NAK_BYTE;
              FrameErr <= 1'b1;
            end
          end
          DATA: begin
            WrEn   <= 1'b1;
            WrAddr <= idx[ADDR_W-1:0];
            WrData <= RxData;
            sum    <= sum + RxData;
            idx    <= idx + 8'd1;
          end
          CSUM: begin
            if (csumOk) begin
              FrameDone <= 1'b1;
              respByte  <= ACK_BYTE;
            end else begin
              FrameErr <= 1'b1;
              respByte <= NAK_BYTE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
